// File: rtl/sfq_rx_pkg.sv
// Shared types and defaults for the SFQ stream receiver.
package sfq_rx_pkg;

  localparam int unsigned WORD_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned PAR_MAX_W      = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Even-parity bit over a zero-extended data word.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sfq_rx_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sfq_rx_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/sfq_stream_receiver.sv
// Deframes a clocked SFQ slot stream (start, data LSB first, stop) into words
// queued in an FWFT FIFO. Define SFQ_RX_PARITY_EN to add an even-parity slot.
module sfq_stream_receiver
  import sfq_rx_pkg::*;
#(
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clkin,
  input  logic                          rst,
  input  logic                          slot_en,
  input  logic                          pulse_in,
  output logic [WORD_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clear_flags,
`ifdef SFQ_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  rx_state_t         state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push_c;
  logic              ferr_c;
  logic              pop_c;
  logic              full_c;
  logic              empty_c;
  logic              drop_c;
`ifdef SFQ_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_c;
`endif

  assign pop_c    = rx_valid & rx_ready;
  assign rx_valid = ~empty_c;
  // A full FIFO still takes the word when the consumer pops in the same cycle.
  assign drop_c   = push_c & full_c & ~pop_c;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
`ifdef SFQ_RX_PARITY_EN
      par_q      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      frame_err <= ferr_c;
      if (drop_c)           overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
`ifdef SFQ_RX_PARITY_EN
      par_q <= par_d;
      if (perr_c)           parity_err <= 1'b1;
      else if (clear_flags) parity_err <= 1'b0;
`endif
    end
  end

  // Slot-driven deframer; holds whenever slot_en is low.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    push_c  = 1'b0;
    ferr_c  = 1'b0;
`ifdef SFQ_RX_PARITY_EN
    par_d   = par_q;
    perr_c  = 1'b0;
`endif
    if (slot_en) begin
      case (state_q)
        IDLE: begin
          if (pulse_in) begin
            state_d = DATA;
            cnt_d   = '0;
            shift_d = '0;
          end
        end
        DATA: begin
          shift_d[cnt_q] = pulse_in;
          cnt_d          = cnt_q + CW'(1);
          if (cnt_q == CW'(WORD_W - 1)) begin
`ifdef SFQ_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef SFQ_RX_PARITY_EN
        PARITY: begin
          par_d   = pulse_in;
          state_d = STOP;
        end
`endif
        STOP: begin
          // A stop-slot pulse is an error, never a new start bit.
          state_d = IDLE;
          if (pulse_in) begin
            ferr_c = 1'b1;
`ifdef SFQ_RX_PARITY_EN
          end else if (par_q != even_parity(PAR_MAX_W'(shift_q))) begin
            perr_c = 1'b1;
`endif
          end else begin
            push_c = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  sfq_rx_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clkin),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (shift_q),
    .dout  (rx_data),
    .full  (full_c),
    .empty (empty_c),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_sfq_stream_receiver.sv
// Scoreboard bench for sfq_stream_receiver: frame-level reference model plus
// per-cycle monitor. Also builds with SFQ_RX_PARITY_EN defined.
module tb_sfq_stream_receiver;

  localparam int DEPTH = 4;

  logic       clkin = 1'b0;
  logic       rst;
  logic       slot_en;
  logic       pulse_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overflow;
  logic       clear_flags;
  logic [2:0] fifo_level;
`ifdef SFQ_RX_PARITY_EN
  logic       parity_err;
  logic       exp_perr = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Frame events announced by the driver on the slot that completes a frame:
  // 0 none, 1 good word, 2 stop-slot pulse, 3 parity mismatch.
  int         ev_code = 0;
  logic [7:0] ev_word = 8'h00;
  logic       rnd_mode = 1'b0;

  int         mlevel   = 0;
  logic       exp_ovf  = 1'b0;
  logic       exp_ferr = 1'b0;
  logic [7:0] exp_q [$];

  always #5 clkin = ~clkin;

  sfq_stream_receiver #(.WORD_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clkin       (clkin),
    .rst         (rst),
    .slot_en     (slot_en),
    .pulse_in    (pulse_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .clear_flags (clear_flags),
`ifdef SFQ_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .fifo_level  (fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue with DEPTH entries and sticky flags.
  always @(posedge clkin or posedge rst) begin
    if (rst) begin
      mlevel   = 0;
      exp_q.delete();
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
`ifdef SFQ_RX_PARITY_EN
      exp_perr = 1'b0;
`endif
    end else begin
      automatic bit pop  = (mlevel > 0) && rx_ready;
      automatic bit acc  = 1'b0;
      automatic bit drop = 1'b0;
      if (ev_code == 1) begin
        if (mlevel < DEPTH || pop) begin
          exp_q.push_back(ev_word);
          acc = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
      mlevel = mlevel + int'(acc) - int'(pop);
      if (drop)             exp_ovf = 1'b1;
      else if (clear_flags) exp_ovf = 1'b0;
      exp_ferr = (ev_code == 2);
`ifdef SFQ_RX_PARITY_EN
      if (ev_code == 3)     exp_perr = 1'b1;
      else if (clear_flags) exp_perr = 1'b0;
`endif
    end
  end

  // Monitor: compares status every cycle and data on every handshake.
  always @(negedge clkin) begin
    if (!rst) begin
      chk("fifo_level", 32'(fifo_level), 32'(mlevel));
      chk("rx_valid", 32'(rx_valid), 32'(mlevel != 0));
      chk("frame_err", 32'(frame_err), 32'(exp_ferr));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef SFQ_RX_PARITY_EN
      chk("parity_err", 32'(parity_err), 32'(exp_perr));
`endif
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_pop: got word %0h expected no word at %0t", rx_data, $time);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cyc(input logic se, input logic p, input int code, input logic [7:0] w);
    @(posedge clkin);
    #1;
    slot_en     = se;
    pulse_in    = p;
    ev_code     = code;
    ev_word     = w;
    clear_flags = 1'b0;
    if (rnd_mode) begin
      rx_ready    = 1'($urandom_range(0, 1));
      clear_flags = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 8'h00);
  endtask

  // gp: pulse level on gap cycles (0/1), or 2 for random.
  task automatic send_frame(input logic [7:0] w, input logic stop_p, input int gap,
                            input int gp, input logic bad_par, input logic rdy_stop);
    logic sl [$];
    int   n;
    sl.push_back(1'b1);
    for (int i = 0; i < 8; i++) sl.push_back(w[i]);
`ifdef SFQ_RX_PARITY_EN
    sl.push_back((^w) ^ bad_par);
`endif
    sl.push_back(stop_p);
    n = sl.size();
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++)
        cyc(1'b0, (gp == 2) ? 1'($urandom_range(0, 1)) : 1'(gp), 0, 8'h00);
      if (i == n - 1) begin
        cyc(1'b1, stop_p, stop_p ? 2 : (bad_par ? 3 : 1), w);
        if (rdy_stop) rx_ready = 1'b1;
      end else begin
        cyc(1'b1, sl[i], 0, 8'h00);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; slot_en = 1'b0; pulse_in = 1'b0; rx_ready = 1'b0; clear_flags = 1'b0;
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    @(posedge clkin); #1; rst = 1'b0;

    // Basic frame, slot every cycle, then gapped slots with pulses on gaps.
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(3);
    send_frame(8'hA5, 1'b0, 2, 1, 1'b0, 1'b0);
    idle(3);

    // Stop-slot pulse, then a back-to-back good frame.
    send_frame(8'h3C, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(3);

    // Overflow on a full FIFO, drain, then clear.
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b0, 0, 0, 1'b0, 1'b0);
    idle(2);
    @(negedge clkin);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    rx_ready = 1'b1;
    idle(6);
    cyc(1'b1, 1'b0, 0, 8'h00);
    clear_flags = 1'b1;
    idle(2);
    @(negedge clkin);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with a pop coinciding with the fifth stop slot.
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 1'b0, 0, 0, 1'b0, 1'b0);
    send_frame(8'h24, 1'b0, 0, 0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 0, 8'h00);
    rx_ready = 1'b0;
    idle(2);
    @(negedge clkin);
    chk("same_cycle_level", 32'(fifo_level), 32'd4);
    chk("same_cycle_ovf", 32'(overflow), 32'd0);
    rx_ready = 1'b1;
    idle(6);

    // Reset in the middle of a frame.
    rx_ready = 1'b0;
    cyc(1'b1, 1'b1, 0, 8'h00);
    cyc(1'b1, 1'b1, 0, 8'h00);
    cyc(1'b1, 1'b0, 0, 8'h00);
    cyc(1'b1, 1'b1, 0, 8'h00);
    cyc(1'b1, 1'b1, 0, 8'h00);
    @(posedge clkin); #1;
    rst = 1'b1; slot_en = 1'b0; pulse_in = 1'b0; ev_code = 0;
    repeat (2) @(posedge clkin);
    #1; rst = 1'b0;
`ifdef SFQ_RX_PARITY_EN
    send_frame(8'hFF, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(3);
    @(negedge clkin);
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    chk("post_rst_perr", 32'(parity_err), 32'd1);
`else
    send_frame(8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
    idle(3);
    @(negedge clkin);
    chk("post_rst_level", 32'(fifo_level), 32'd1);
`endif
    rx_ready = 1'b1;
    idle(3);

    // Randomized frames, gaps, stop errors, back-pressure and flag clears.
    rnd_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      automatic logic sp = ($urandom_range(0, 7) == 0);
`ifdef SFQ_RX_PARITY_EN
      automatic logic bp = ($urandom_range(0, 7) == 0);
`else
      automatic logic bp = 1'b0;
`endif
      send_frame(8'($urandom), sp, $urandom_range(0, 2), 2, bp, 1'b0);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        if ($urandom_range(0, 1) == 1) cyc(1'b1, 1'b0, 0, 8'h00);
        else cyc(1'b0, 1'($urandom_range(0, 1)), 0, 8'h00);
      end
    end
    rnd_mode = 1'b0;
    rx_ready = 1'b1;
    idle(8);
    @(negedge clkin);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
